btn_debounce: RTL and testbench

- Front-end conditioning stage that feeds the DDS top's 6-bit button bus.
- Synchronises raw push-button inputs, debounces them and produces a clean level per button.
- Emits one-cycle press and release pulses, plus auto-repeat pulses while a button is held, so frequency/phase step controls can ramp.
- Sits between the board pins and the top's mode/step control logic.

---
 rtl/dds_btn_pkg.sv | 24 ++
 rtl/btn_debounce_channel.sv | 127 ++++++++++++
 rtl/btn_debounce.sv | 38 +++
 tb/tb_btn_debounce.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_btn_pkg.sv
// Shared types and cycle constants for the DDS button front end.
package dds_btn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rpt_state_e;

  // 100 MHz board timing
  localparam int DEBOUNCE_CYC_HW     = 2_000_000;
  localparam int REPEAT_DELAY_CYC_HW = 50_000_000;
  localparam int REPEAT_RATE_CYC_HW  = 10_000_000;

  // Shrunk timing for simulation
  localparam int DEBOUNCE_CYC_SIM     = 4;
  localparam int REPEAT_DELAY_CYC_SIM = 20;
  localparam int REPEAT_RATE_CYC_SIM  = 5;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_debounce_channel.sv
// One button: 2-flop synchroniser, debounce counter and auto-repeat FSM.
module btn_channel
  import dds_btn_pkg::*;
#(
  parameter int DEBOUNCE_CYC     = DEBOUNCE_CYC_HW,
  parameter int REPEAT_DELAY_CYC = REPEAT_DELAY_CYC_HW,
  parameter int REPEAT_RATE_CYC  = REPEAT_RATE_CYC_HW,
  parameter int REPEAT_EN        = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_repeat
);

  localparam int DW = $clog2(DEBOUNCE_CYC + 1);

  logic          sync1;
  logic          sync2;
  logic [DW-1:0] db_cnt;
  logic          differ;
  logic          accept;
  logic          rise;
  logic          fall;

  assign differ = sync2 ^ btn_level;
  assign accept = differ && (db_cnt == DW'(DEBOUNCE_CYC - 1));
  assign rise   = accept && !btn_level;
  assign fall   = accept && btn_level;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      db_cnt      <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      sync1       <= btn_in;
      sync2       <= sync1;
      btn_press   <= rise;
      btn_release <= fall;
      if (!differ || accept) begin
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
      if (accept) begin
        btn_level <= ~btn_level;
      end
    end
  end

  if (REPEAT_EN != 0) begin : g_rpt
    localparam int RMAX = max_int(REPEAT_DELAY_CYC, REPEAT_RATE_CYC);
    localparam int RW   = $clog2(RMAX + 1);

    rpt_state_e    state_q;
    rpt_state_e    state_d;
    logic [RW-1:0] cnt_q;
    logic [RW-1:0] cnt_d;
    logic          rpt_q;
    logic          rpt_d;

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        rpt_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        rpt_q   <= rpt_d;
      end
    end

    // Release wins over a terminal count in the same cycle
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rpt_d   = 1'b0;
      if (fall) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (rise) begin
              state_d = DELAY;
              cnt_d   = '0;
            end
          end
          DELAY: begin
            if (cnt_q == RW'(REPEAT_DELAY_CYC - 1)) begin
              rpt_d   = 1'b1;
              state_d = REPEAT;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          REPEAT: begin
            if (cnt_q == RW'(REPEAT_RATE_CYC - 1)) begin
              rpt_d = 1'b1;
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          default: begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        endcase
      end
    end

    assign btn_repeat = rpt_q;
  end else begin : g_no_rpt
    assign btn_repeat = 1'b0;
  end

endmodule

// File: rtl/btn_debounce.sv
// Button conditioning front end for the DDS top: one
// btn_channel per push-button, all channels independent.
module btn_debounce
  import dds_btn_pkg::*;
#(
  parameter int N_BTN            = 6,
  parameter int DEBOUNCE_CYC     = DEBOUNCE_CYC_HW,
  parameter int REPEAT_DELAY_CYC = REPEAT_DELAY_CYC_HW,
  parameter int REPEAT_RATE_CYC  = REPEAT_RATE_CYC_HW,
  parameter int REPEAT_EN        = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYC     (DEBOUNCE_CYC),
      .REPEAT_DELAY_CYC (REPEAT_DELAY_CYC),
      .REPEAT_RATE_CYC  (REPEAT_RATE_CYC),
      .REPEAT_EN        (REPEAT_EN)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .btn_in      (btn_in[i]),
      .btn_level   (btn_level[i]),
      .btn_press   (btn_press[i]),
      .btn_release (btn_release[i]),
      .btn_repeat  (btn_repeat[i])
    );
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Scoreboard bench for btn_debounce, with and without auto-repeat.
module tb_btn_debounce;
  import dds_btn_pkg::*;

  localparam int LAT = DEBOUNCE_CYC_SIM + 2;
  localparam int RD  = REPEAT_DELAY_CYC_SIM;
  localparam int RR  = REPEAT_RATE_CYC_SIM;

  typedef struct {
    int         cyc;
    logic [5:0] pr;
    logic [5:0] rl;
    logic [5:0] rp;
    logic [5:0] lv;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [5:0] btn_in;
  logic [5:0] lv_a, pr_a, rl_a, rp_a;
  logic [5:0] lv_b, pr_b, rl_b, rp_b;

  int   cyc;
  logic rst_at_edge;
  int   errors;
  int   checks;
  exp_t q_en[$];
  exp_t q_nr[$];

  btn_debounce #(
    .N_BTN(6), .DEBOUNCE_CYC(DEBOUNCE_CYC_SIM),
    .REPEAT_DELAY_CYC(RD), .REPEAT_RATE_CYC(RR), .REPEAT_EN(1)
  ) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .btn_level(lv_a), .btn_press(pr_a),
    .btn_release(rl_a), .btn_repeat(rp_a)
  );

  btn_debounce #(
    .N_BTN(6), .DEBOUNCE_CYC(DEBOUNCE_CYC_SIM),
    .REPEAT_DELAY_CYC(RD), .REPEAT_RATE_CYC(RR), .REPEAT_EN(0)
  ) dut_nr (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .btn_level(lv_b), .btn_press(pr_b),
    .btn_release(rl_b), .btn_repeat(rp_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    rst_at_edge = 1'b0;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rst_at_edge <= rst;
  end

  function automatic void push(
    input int c, input logic [5:0] pr, input logic [5:0] rl,
    input logic [5:0] rp, input logic [5:0] lv);
    exp_t e;
    e.cyc = c; e.pr = pr; e.rl = rl; e.rp = rp; e.lv = lv;
    q_en.push_back(e);
    if ((pr | rl) != 6'h00) begin
      e.rp = 6'h00;
      q_nr.push_back(e);
    end
  endfunction

  task automatic pop_due(input bit nr, output bit have, output exp_t e);
    have = 1'b0;
    e = '{0, 6'h0, 6'h0, 6'h0, 6'h0};
    if (nr) begin
      if (q_nr.size() > 0 && q_nr[0].cyc <= cyc) begin
        e = q_nr.pop_front();
        have = 1'b1;
      end
    end else begin
      if (q_en.size() > 0 && q_en[0].cyc <= cyc) begin
        e = q_en.pop_front();
        have = 1'b1;
      end
    end
  endtask

  task automatic mon(input bit nr, input logic [5:0] lv,
                     input logic [5:0] pr, input logic [5:0] rl,
                     input logic [5:0] rp);
    exp_t e;
    bit   have;
    if (rst_at_edge) begin
      checks++;
      if ({lv, pr, rl, rp} != 24'h0) begin
        errors++;
        $display("FAIL rst_clear dut%0d cyc=%0d got lv=%h pr=%h rl=%h rp=%h want all 0",
                 nr, cyc, lv, pr, rl, rp);
      end
    end
    pop_due(nr, have, e);
    while (have && e.cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL missed dut%0d cyc=%0d got nothing want pr=%h rl=%h rp=%h at %0d",
               nr, cyc, e.pr, e.rl, e.rp, e.cyc);
      pop_due(nr, have, e);
    end
    if (have) begin
      checks++;
      if (pr !== e.pr || rl !== e.rl || rp !== e.rp || lv !== e.lv) begin
        errors++;
        $display("FAIL event dut%0d cyc=%0d got pr=%h rl=%h rp=%h lv=%h want pr=%h rl=%h rp=%h lv=%h",
                 nr, cyc, pr, rl, rp, lv, e.pr, e.rl, e.rp, e.lv);
      end
    end else if ((pr | rl | rp) != 6'h00) begin
      checks++;
      errors++;
      $display("FAIL unexpected dut%0d cyc=%0d got pr=%h rl=%h rp=%h want none",
               nr, cyc, pr, rl, rp);
    end
  endtask

  always @(negedge clk) begin
    if (cyc > 0) begin
      mon(1'b0, lv_a, pr_a, rl_a, rp_a);
      mon(1'b1, lv_b, pr_b, rl_b, rp_b);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) step(1);
  endtask

  initial begin
    int p;
    errors = 0;
    checks = 0;
    rst = 1'b1;
    btn_in = 6'h3F;
    // all buttons held through reset
    step(3);
    rst = 1'b0;
    push(cyc + LAT, 6'h3F, 6'h00, 6'h00, 6'h3F);
    wait_to(10);
    btn_in = 6'h00;
    push(cyc + LAT, 6'h00, 6'h3F, 6'h00, 6'h00);

    // clean press, hold shorter than repeat delay
    wait_to(20);
    btn_in = 6'h01;
    push(cyc + LAT, 6'h01, 6'h00, 6'h00, 6'h01);
    wait_to(35);
    btn_in = 6'h00;
    push(cyc + LAT, 6'h00, 6'h01, 6'h00, 6'h00);

    // 3-cycle glitch then bouncing
    wait_to(50);
    btn_in = 6'h02;
    wait_to(53);
    btn_in = 6'h00;
    for (int k = 0; k < 6; k++) begin
      wait_to(60 + 2 * k);
      btn_in = (k % 2 == 0) ? 6'h02 : 6'h00;
    end
    wait_to(72);
    btn_in = 6'h02;
    push(cyc + LAT, 6'h02, 6'h00, 6'h00, 6'h02);
    wait_to(80);
    btn_in = 6'h00;
    push(cyc + LAT, 6'h00, 6'h02, 6'h00, 6'h00);

    // auto-repeat; release lands on a terminal count
    wait_to(90);
    btn_in = 6'h04;
    p = cyc + LAT;
    push(p, 6'h04, 6'h00, 6'h00, 6'h04);
    for (int k = 0; k < 8; k++)
      push(p + RD + RR * k, 6'h00, 6'h00, 6'h04, 6'h04);
    wait_to(150);
    btn_in = 6'h00;
    push(cyc + LAT, 6'h00, 6'h04, 6'h00, 6'h00);

    // simultaneous press, reset while repeating
    wait_to(170);
    btn_in = 6'h21;
    p = cyc + LAT;
    push(p, 6'h21, 6'h00, 6'h00, 6'h21);
    for (int k = 0; k < 3; k++)
      push(p + RD + RR * k, 6'h00, 6'h00, 6'h21, 6'h21);
    wait_to(208);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    p = cyc + LAT;
    push(p, 6'h21, 6'h00, 6'h00, 6'h21);
    for (int k = 0; k < 2; k++)
      push(p + RD + RR * k, 6'h00, 6'h00, 6'h21, 6'h21);
    wait_to(236);
    btn_in = 6'h00;
    push(cyc + LAT, 6'h00, 6'h21, 6'h00, 6'h00);

    // release on one bit and press on another together
    wait_to(250);
    btn_in = 6'h08;
    push(cyc + LAT, 6'h08, 6'h00, 6'h00, 6'h08);
    wait_to(262);
    btn_in = 6'h10;
    push(cyc + LAT, 6'h10, 6'h08, 6'h00, 6'h10);
    wait_to(270);
    btn_in = 6'h00;
    push(cyc + LAT, 6'h00, 6'h10, 6'h00, 6'h00);

    wait_to(295);
    while (q_en.size() > 0) begin
      exp_t e;
      e = q_en.pop_front();
      checks++;
      errors++;
      $display("FAIL leftover dut0 got nothing want pr=%h rl=%h rp=%h at %0d",
               e.pr, e.rl, e.rp, e.cyc);
    end
    while (q_nr.size() > 0) begin
      exp_t e;
      e = q_nr.pop_front();
      checks++;
      errors++;
      $display("FAIL leftover dut1 got nothing want pr=%h rl=%h at %0d",
               e.pr, e.rl, e.cyc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
